// File: rtl/bin_conv_pkg.sv
// Shared types and reference conversion for the binary-to-BCD display path.
// Used by bin2bcd_core, bin_converter and the bench.
package bin_conv_pkg;

  localparam int BCD_W   = 4;
  localparam int EXT_W   = 6;
  localparam int MAX_IN_W = 6;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t ten;
    bcd_digit_t unit;
  } bcd2_t;

  // Arithmetic reference: the value a correct double-dabble core must produce.
  function automatic bcd2_t bin2bcd(input logic [EXT_W-1:0] value);
    bcd2_t r;
    r.ten  = BCD_W'(value / EXT_W'(10));
    r.unit = BCD_W'(value % EXT_W'(10));
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_core.sv
// Combinational shift-add-3 (double-dabble) converter for inputs up to 6 bits.
// Produces two BCD digits; tens never exceeds 6 for the legal width range.
module bin2bcd_core
  import bin_conv_pkg::*;
#(
  parameter int IN_W = 5
) (
  input  logic [IN_W-1:0] bin,
  output bcd2_t           bcd
);

  localparam int LEAD = EXT_W - IN_W;
  localparam int SCR_W = 2 * BCD_W + EXT_W;

  logic [EXT_W-1:0] bin_ext;
  logic [SCR_W-1:0] scratch;

  assign bin_ext = EXT_W'(bin);

  // NOTE: blocking assignments are intended here; each loop pass reads the
  // result of the previous one within the same combinational evaluation.
  always_comb begin
    scratch = '0;
    // Left-align the operand so exactly IN_W shifts bring it into the BCD field.
    scratch[EXT_W-1:0] = bin_ext << LEAD;
    for (int i = 0; i < IN_W; i++) begin
      if (scratch[EXT_W +: BCD_W] >= BCD_W'(5))
        scratch[EXT_W +: BCD_W] = scratch[EXT_W +: BCD_W] + BCD_W'(3);
      if (scratch[EXT_W+BCD_W +: BCD_W] >= BCD_W'(5))
        scratch[EXT_W+BCD_W +: BCD_W] = scratch[EXT_W+BCD_W +: BCD_W] + BCD_W'(3);
      scratch = scratch << 1;
    end
  end

  assign bcd.unit = scratch[EXT_W +: BCD_W];
  assign bcd.ten  = scratch[EXT_W+BCD_W +: BCD_W];

endmodule

// File: rtl/bin_converter.sv
// Binary (0..2^IN_W-1) to two registered BCD digits, one cycle of latency.
// Optional input/output qualifiers when BIN_CONV_VALID_EN is defined.
module bin_converter
  import bin_conv_pkg::*;
#(
  parameter int IN_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  bin_6,
  output logic [BCD_W-1:0] bin_unit,
  output logic [BCD_W-1:0] bin_ten
`ifdef BIN_CONV_VALID_EN
  ,
  input  logic             in_valid,
  output logic             out_valid
`endif
);

  // Widths above 6 would let the tens digit exceed 9.
  if (IN_W < 1 || IN_W > MAX_IN_W) begin : g_bad_width
    $error("bin_converter: IN_W must be in 1..6");
  end

  bcd2_t conv;
  bcd2_t result_q;

  bin2bcd_core #(.IN_W(IN_W)) u_core (
    .bin (bin_6),
    .bcd (conv)
  );

`ifdef BIN_CONV_VALID_EN
  logic valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) result_q <= conv;
    end
  end

  assign out_valid = valid_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) result_q <= '0;
    else        result_q <= conv;
  end
`endif

  assign bin_unit = result_q.unit;
  assign bin_ten  = result_q.ten;

endmodule

// File: tb/tb_bin_converter.sv
// Self-checking bench for bin_converter: directed boundaries, reset, random
// stream against an arithmetic model, exhaustive sweep, optional valid mode.
module tb_bin_converter;
  import bin_conv_pkg::*;

  localparam int IN_W = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [IN_W-1:0] bin_6 = '0;
  logic [3:0]      bin_unit;
  logic [3:0]      bin_ten;
`ifdef BIN_CONV_VALID_EN
  logic            in_valid = 1'b1;
  logic            out_valid;
`endif

  int total = 0;
  int bad   = 0;

  bin_converter #(.IN_W(IN_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bin_6    (bin_6),
    .bin_unit (bin_unit),
    .bin_ten  (bin_ten)
`ifdef BIN_CONV_VALID_EN
    ,
    .in_valid (in_valid),
    .out_valid(out_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected digits come straight from decimal arithmetic on the driven value.
  task automatic check_value(input string tag, input int v);
    check({tag, "_unit"}, bin_unit, 4'(v % 10));
    check({tag, "_ten"},  bin_ten,  4'(v / 10));
  endtask

  task automatic apply(input string tag, input int v);
    @(negedge clk);
    bin_6 = IN_W'(v);
    @(posedge clk);
    #1;
    check_value(tag, v);
  endtask

  initial begin
    bcd2_t ref_bcd;
    int    v;

    // Reset held with a live operand: outputs stay zero.
    bin_6 = IN_W'(23);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_value("reset_hold", 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_value("reset_release_23", 23);

    apply("v19", 19);
    apply("v9", 9);
    apply("v10_roll", 10);
    apply("v0", 0);
    apply("v31_max", 31);

    // Back-to-back random stream, one new operand every cycle.
    for (int i = 0; i < 40; i++) begin
      v = int'($urandom_range(0, (1 << IN_W) - 1));
      apply("random", v);
    end

    // Asynchronous reset mid-cycle.
    apply("v30", 30);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("async_reset", 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_value("after_async_30", 30);

    // Exhaustive sweep against both the model and the package reference.
    for (int i = 0; i < (1 << IN_W); i++) begin
      apply("sweep", i);
      ref_bcd = bin2bcd(6'(i));
      check("sweep_pkg_unit", bin_unit, ref_bcd.unit);
      check("sweep_pkg_ten",  bin_ten,  ref_bcd.ten);
      check("sweep_unit_range", 4'(bin_unit <= 4'd9), 4'd1);
      check("sweep_ten_range",  4'(bin_ten <= 4'd3),  4'd1);
    end

`ifdef BIN_CONV_VALID_EN
    apply("valid_seed", 5);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bin_6 = IN_W'(20 + i);
      @(posedge clk);
      #1;
      check_value("valid_hold", 5);
      check("valid_hold_ov", 4'(out_valid), 4'd0);
      @(negedge clk);
    end
    bin_6 = IN_W'(17);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_value("valid_17", 17);
    check("valid_pulse_ov", 4'(out_valid), 4'd1);
    @(negedge clk);
    in_valid = 1'b0;
    bin_6 = IN_W'(2);
    @(posedge clk);
    #1;
    check_value("valid_17_hold", 17);
    check("valid_pulse_end_ov", 4'(out_valid), 4'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
